i2s_tdm_tx: RTL and testbench

- Parametrised serial audio transmitter that drives I2S_BCK, I2S_LRCK and I2S_DATA from parallel PCM samples.
- Successor to the fixed stereo 16-bit I2S output. Adds configurable sample and slot width, channel count, and three framing modes: I2S, left-justified and TDM.
- Adds a valid/ready sample handshake and underrun reporting.
- Sits between the audio mixer and the board I2S pins inside the core wrapper.

---
 rtl/i2s_tdm_tx.sv | 167 ++++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_tx.sv
// ============================================================================
// Module   : i2s_tdm_tx
// Brief    : Parallel PCM to I2S / left-justified / TDM serial transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2s_tdm_tx #(
    parameter int SAMPLE_BITS        = 16,
    parameter int SLOT_BITS          = 32,
    parameter int CHANNELS           = 2,
    parameter int CLK_DIV            = 4,
    parameter int REPEAT_ON_UNDERRUN = 1
) (
    input  logic                            clk_sys,
    input  logic                            reset,
    input  logic [1:0]                      cfg_mode,
    input  logic [CHANNELS*SAMPLE_BITS-1:0] sample_data,
    input  logic                            sample_valid,
    output logic                            sample_ready,
    output logic                            underrun,
    output logic                            I2S_BCK,
    output logic                            I2S_LRCK,
    output logic                            I2S_DATA
);

    localparam int c_FRAME_BITS = CHANNELS * SLOT_BITS;
    localparam int c_PCM_W      = CHANNELS * SAMPLE_BITS;
    localparam int c_DIV_W      = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
    localparam int c_BIT_W      = (c_FRAME_BITS > 1) ? $clog2(c_FRAME_BITS) : 1;
    localparam int c_SLOT_W     = (SLOT_BITS > 1)    ? $clog2(SLOT_BITS)    : 1;
    localparam int c_CH_W       = (CHANNELS > 1)     ? $clog2(CHANNELS)     : 1;
    localparam int c_IDX_W      = (c_PCM_W > 1)      ? $clog2(c_PCM_W)      : 1;

    logic [c_DIV_W-1:0]  r_div;
    logic                r_bck;
    logic                r_lrck;
    logic                r_data;
    logic                r_underrun;
    logic                r_first;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [c_SLOT_W-1:0] r_slot_bit;
    logic [c_CH_W-1:0]   r_slot;
    logic [1:0]          r_mode;
    logic [c_PCM_W-1:0]  r_hold;
    logic                r_hold_full;
    logic [c_PCM_W-1:0]  r_buf;

    logic                w_tc;
    logic                w_fall;
    logic                w_start;
    logic                w_slot_end;
    logic                w_accept;
    logic [1:0]          w_mode_in;
    logic [1:0]          w_nmode;
    logic [c_PCM_W-1:0]  w_fill;
    logic [c_PCM_W-1:0]  w_buf_next;
    logic [c_BIT_W-1:0]  w_nbit;
    logic [c_SLOT_W-1:0] w_nslot_bit;
    logic [c_CH_W-1:0]   w_nslot;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_ndata;
    logic                w_nlrck;
    int                  w_offset;
    int                  w_pos;

    assign w_tc       = (r_div == c_DIV_W'(CLK_DIV - 1));
    assign w_fall     = w_tc & r_bck;
    // r_first forces the very first fall tick after reset to open a frame
    assign w_start    = w_fall & (r_first | (r_bit_cnt == c_BIT_W'(c_FRAME_BITS - 1)));
    assign w_slot_end = (r_slot_bit == c_SLOT_W'(SLOT_BITS - 1));
    assign w_accept   = sample_valid & ~r_hold_full;
    assign w_mode_in  = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
    assign w_nmode    = w_start ? w_mode_in : r_mode;

    generate
        if (REPEAT_ON_UNDERRUN != 0) begin : g_repeat
            assign w_fill = r_buf;
        end else begin : g_zero
            assign w_fill = '0;
        end
    endgenerate

    assign w_buf_next  = w_start ? (r_hold_full ? r_hold : w_fill) : r_buf;
    assign w_nbit      = w_start ? '0 : r_bit_cnt + 1'b1;
    assign w_nslot_bit = (w_start | w_slot_end) ? '0 : r_slot_bit + 1'b1;
    assign w_nslot     = w_start ? '0 : (w_slot_end ? r_slot + 1'b1 : r_slot);

    // Serial bit for the position about to be driven, MSB first at offset d
    always_comb begin
        w_offset = (w_nmode == 2'd1) ? 0 : 1;
        w_pos    = int'(w_nslot_bit) - w_offset;
        w_idx    = '0;
        w_ndata  = 1'b0;
        if (w_pos >= 0 && w_pos < SAMPLE_BITS) begin
            w_idx   = c_IDX_W'(int'(w_nslot) * SAMPLE_BITS + SAMPLE_BITS - 1 - w_pos);
            w_ndata = w_buf_next[w_idx];
        end
    end

    always_comb begin
        case (w_nmode)
            2'd1:    w_nlrck = (w_nslot == '0);
            2'd2:    w_nlrck = (w_nbit == '0);
            default: w_nlrck = w_nslot[0];
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_div       <= '0;
            r_bck       <= 1'b0;
            r_lrck      <= 1'b0;
            r_data      <= 1'b0;
            r_underrun  <= 1'b0;
            r_first     <= 1'b1;
            r_bit_cnt   <= '0;
            r_slot_bit  <= '0;
            r_slot      <= '0;
            r_mode      <= 2'd0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_buf       <= '0;
        end else begin
            if (w_tc) begin
                r_div <= '0;
                r_bck <= ~r_bck;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_fall) begin
                r_bit_cnt  <= w_nbit;
                r_slot_bit <= w_nslot_bit;
                r_slot     <= w_nslot;
                r_data     <= w_ndata;
                r_lrck     <= w_nlrck;
                r_first    <= 1'b0;
            end

            if (w_start) begin
                r_mode <= w_mode_in;
                r_buf  <= w_buf_next;
            end

            r_underrun <= w_start & ~r_hold_full;

            // An accept never coincides with a drain because ready is low while full
            if (w_accept) begin
                r_hold      <= sample_data;
                r_hold_full <= 1'b1;
            end else if (w_start && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign sample_ready = ~r_hold_full;
    assign underrun     = r_underrun;
    assign I2S_BCK      = r_bck;
    assign I2S_LRCK     = r_lrck;
    assign I2S_DATA     = r_data;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tdm_tx.sv
// ============================================================================
// Module   : tb_i2s_tdm_tx
// Brief    : Directed self-checking bench for i2s_tdm_tx (I2S, LJ, TDM).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2s_tdm_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode [3];
    logic [2:0]  valid;
    logic [2:0]  ready, ur, bck, lrck, dat;
    logic [31:0] d0;
    logic [63:0] d1;
    logic [31:0] d2;

    always #5 clk = ~clk;

    // u0: stereo repeat, u1: 4-channel TDM repeat, u2: stereo send-zeros
    i2s_tdm_tx #(.SAMPLE_BITS(16), .SLOT_BITS(32), .CHANNELS(2), .CLK_DIV(2), .REPEAT_ON_UNDERRUN(1)) u0 (
        .clk_sys(clk), .reset(rst), .cfg_mode(mode[0]), .sample_data(d0), .sample_valid(valid[0]),
        .sample_ready(ready[0]), .underrun(ur[0]), .I2S_BCK(bck[0]), .I2S_LRCK(lrck[0]), .I2S_DATA(dat[0]));
    i2s_tdm_tx #(.SAMPLE_BITS(16), .SLOT_BITS(32), .CHANNELS(4), .CLK_DIV(2), .REPEAT_ON_UNDERRUN(1)) u1 (
        .clk_sys(clk), .reset(rst), .cfg_mode(mode[1]), .sample_data(d1), .sample_valid(valid[1]),
        .sample_ready(ready[1]), .underrun(ur[1]), .I2S_BCK(bck[1]), .I2S_LRCK(lrck[1]), .I2S_DATA(dat[1]));
    i2s_tdm_tx #(.SAMPLE_BITS(16), .SLOT_BITS(32), .CHANNELS(2), .CLK_DIV(2), .REPEAT_ON_UNDERRUN(0)) u2 (
        .clk_sys(clk), .reset(rst), .cfg_mode(mode[2]), .sample_data(d2), .sample_valid(valid[2]),
        .sample_ready(ready[2]), .underrun(ur[2]), .I2S_BCK(bck[2]), .I2S_LRCK(lrck[2]), .I2S_DATA(dat[2]));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int guard;
    int fl [3] = '{64, 128, 64};
    int rises [3];
    int falls [3];
    int pend [3];
    int rc1 [3];
    int rc2 [3];
    logic prev_bck [3];
    logic last_rdy [3];
    logic [127:0] cap_d [3][4];
    logic [127:0] cap_l [3][4];
    logic ur_fs [3][4];
    logic ur_nx [3][4];
    logic rdy_fs [3][4];
    logic rdy_pre [3][4];
    logic rdy_nx [3][4];
    logic [127:0] e_m0, e_m1, e_tdm;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] place(input logic [127:0] img, input int start, input logic [15:0] v);
        logic [127:0] r;
        r = img;
        for (int i = 0; i < 16; i++) r[start + i] = v[15 - i];
        return r;
    endfunction

    // One clk_sys cycle; wire activity is observed at the falling clk edge
    task automatic tick();
        int f, b;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                rises[k] = 0; falls[k] = 0; pend[k] = 0; rc1[k] = 0; rc2[k] = 0;
                prev_bck[k] = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    cap_d[k][j] = '0; cap_l[k][j] = '0;
                    ur_fs[k][j] = 1'bx; ur_nx[k][j] = 1'bx;
                    rdy_fs[k][j] = 1'bx; rdy_pre[k][j] = 1'bx; rdy_nx[k][j] = 1'bx;
                end
            end else begin
                if (pend[k] > 0) begin
                    ur_nx[k][pend[k] - 1]  = ur[k];
                    rdy_nx[k][pend[k] - 1] = ready[k];
                    pend[k] = 0;
                end
                if (bck[k] && !prev_bck[k]) begin
                    if (rises[k] == 1) rc1[k] = cyc;
                    if (rises[k] == 2) rc2[k] = cyc;
                    if (rises[k] >= 1) begin
                        f = (rises[k] - 1) / fl[k];
                        b = (rises[k] - 1) % fl[k];
                        if (f < 4) begin
                            cap_d[k][f][b] = dat[k];
                            cap_l[k][f][b] = lrck[k];
                        end
                    end
                    rises[k]++;
                end
                if (!bck[k] && prev_bck[k]) begin
                    f = falls[k] / fl[k];
                    if ((falls[k] % fl[k]) == 0 && f < 4) begin
                        ur_fs[k][f]   = ur[k];
                        rdy_fs[k][f]  = ready[k];
                        rdy_pre[k][f] = last_rdy[k];
                        pend[k]       = f + 1;
                    end
                    falls[k]++;
                end
            end
            prev_bck[k] = bck[k];
            last_rdy[k] = ready[k];
        end
    endtask

    initial begin
        e_m0  = place(place(128'h0, 1, 16'hA55A), 33, 16'h8001);
        e_m1  = place(place(128'h0, 0, 16'hA55A), 32, 16'h8001);
        e_tdm = place(place(place(place(128'h0, 1, 16'h1111), 33, 16'h2222), 65, 16'h3333), 97, 16'h4444);

        d0 = {16'h8001, 16'hA55A};
        d2 = {16'h8001, 16'hA55A};
        d1 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        mode[0] = 2'd0; mode[1] = 2'd2; mode[2] = 2'd0;
        valid = 3'b111;
        rst   = 1'b1;

        // Reset with valid asserted: outputs idle, ready stays high
        repeat (5) tick();
        chk("rst_u0", {bck[0], lrck[0], dat[0], ready[0], ur[0]}, 5'b00010);
        chk("rst_u1", {bck[1], lrck[1], dat[1], ready[1], ur[1]}, 5'b00010);
        chk("rst_u2", {bck[2], lrck[2], dat[2], ready[2], ur[2]}, 5'b00010);
        rst = 1'b0;

        // One sample per instance, then starve them
        guard = 0;
        while (rises[1] < 1 + 2 * 128 && guard < 4000) begin
            tick();
            for (int k = 0; k < 3; k++) if (valid[k] && !ready[k]) valid[k] = 1'b0;
            guard++;
        end
        chk("phase_a_timeout", guard < 4000, 1'b1);
        chk("bck_period", rc2[0] - rc1[0], 4);
        chk("m0_data_f0", cap_d[0][0], e_m0);
        chk("m0_lrck_f0", cap_l[0][0], 128'hFFFFFFFF_00000000);
        chk("m0_repeat_f1", cap_d[0][1], e_m0);
        chk("m0_ur_f0", ur_fs[0][0], 1'b0);
        chk("m0_ur_f1", ur_fs[0][1], 1'b1);
        chk("m0_ur_pulse_end", ur_nx[0][1], 1'b0);
        chk("m0_ready_f0", rdy_fs[0][0], 1'b1);
        chk("tdm_data_f0", cap_d[1][0], e_tdm);
        chk("tdm_lrck_f0", cap_l[1][0], 128'h1);
        chk("tdm_repeat_f1", cap_d[1][1], e_tdm);
        chk("tdm_ur_f1", ur_fs[1][1], 1'b1);
        chk("zero_data_f0", cap_d[2][0], e_m0);
        chk("zero_data_f1", cap_d[2][1], 128'h0);
        chk("zero_ur_f1", ur_fs[2][1], 1'b1);

        // Continuous valid on u0; switch to mode 1 at frame 1 bit 20
        rst = 1'b1;
        valid = 3'b001;
        mode[0] = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
        guard = 0;
        while (rises[0] < 1 + 3 * 64 && guard < 2000) begin
            tick();
            if (mode[0] == 2'd0 && falls[0] == 64 + 21) mode[0] = 2'd1;
            guard++;
        end
        chk("phase_b_timeout", guard < 2000, 1'b1);
        chk("hs_data_f0", cap_d[0][0], e_m0);
        chk("midmode_data_f1", cap_d[0][1], e_m0);
        chk("midmode_lrck_f1", cap_l[0][1], 128'hFFFFFFFF_00000000);
        chk("m1_data_f2", cap_d[0][2], e_m1);
        chk("m1_lrck_f2", cap_l[0][2], 128'h00000000_FFFFFFFF);
        chk("hs_ur_f0", ur_fs[0][0], 1'b0);
        for (int f = 1; f < 3; f++) begin
            chk($sformatf("hs_ready_pre_f%0d", f), rdy_pre[0][f], 1'b0);
            chk($sformatf("hs_ready_fs_f%0d", f), rdy_fs[0][f], 1'b1);
            chk($sformatf("hs_ready_nx_f%0d", f), rdy_nx[0][f], 1'b0);
            chk($sformatf("hs_ur_f%0d", f), ur_fs[0][f], 1'b0);
        end

        // Reset while BCK is high during frame 3 bit 20
        guard = 0;
        while (!(falls[0] == 3 * 64 + 21 && bck[0]) && guard < 1000) begin
            tick();
            guard++;
        end
        chk("phase_c_timeout", guard < 1000, 1'b1);
        chk("midrst_before", {bck[0], lrck[0], dat[0], ready[0], ur[0]}, 5'b11000);
        rst = 1'b1;
        tick();
        chk("midrst_after", {bck[0], lrck[0], dat[0], ready[0], ur[0]}, 5'b00010);
        rst = 1'b0;
        guard = 0;
        while (rises[0] < 1 + 64 && guard < 1000) begin
            tick();
            guard++;
        end
        chk("restart_timeout", guard < 1000, 1'b1);
        chk("restart_data_f0", cap_d[0][0], e_m1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
